mcpu_fetch_unit: RTL

Instruction fetch stage of the micro-CPU. It sits directly upstream of `MCPU_RAMController` and drives the controller's instruction address port (`instraddr`) from a program counter. Each returned byte (`instrrd`) is captured into a small prefetch buffer, which presents `{pc, instruction}` pairs to the decode stage over a valid/ready handshake. Jump and branch redirects from execute flush the buffer and reload the PC.

---
 rtl/mcpu_pkg.sv | 18 +
 rtl/mcpu_fetch_fifo.sv | 67 ++++++
 rtl/mcpu_fetch_unit.sv | 61 ++++++
 3 files changed

// File: rtl/mcpu_pkg.sv
// Shared micro-CPU constants and fetch types, common to the fetch unit and RAM controller.
// WORD_SIZE/ADDR_WIDTH here must agree with the RAM controller build.
package mcpu_pkg;

   localparam int WORD_SIZE  = 8;
   localparam int ADDR_WIDTH = 8;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [WORD_SIZE-1:0]  word;
   } fetch_entry_t;

   // A depth-1 buffer still carries a 1-bit pointer so every index stays a legal vector.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mcpu_fetch_fifo.sv
// Prefetch buffer for the fetch stage: DEPTH entries of {addr, word}, FIFO order.
// Flush wins over push and pop; a push into a full buffer is accepted only alongside a pop.
module mcpu_fetch_fifo
   import mcpu_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] push_addr,
   input  logic [WORD_SIZE-1:0]  push_word,
   input  logic                  pop,
   output logic [CNT_W-1:0]      count,
   output logic [ADDR_WIDTH-1:0] head_addr,
   output logic [WORD_SIZE-1:0]  head_word
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int SLOTS = 1 << PTR_W;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   fetch_entry_t     mem [SLOTS];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] adv(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL) || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= '{addr: push_addr, word: push_word};
            wr_ptr      <= adv(wr_ptr);
         end
         if (do_pop) rd_ptr <= adv(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // When full, head and tail share a slot; the head is read before the edge overwrites it.
   assign head_addr = mem[rd_ptr].addr;
   assign head_word = mem[rd_ptr].word;

endmodule

// File: rtl/mcpu_fetch_unit.sv
// Instruction fetch stage: PC drives the RAM instruction port, bytes queue for decode.
// MCPU_FETCH_PREFETCH_EN selects a 2-deep prefetch buffer; otherwise a single output register.
module mcpu_fetch_unit #(
   parameter int                    WORD_SIZE  = mcpu_pkg::WORD_SIZE,
   parameter int                    ADDR_WIDTH = mcpu_pkg::ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] instraddr,
   input  logic [WORD_SIZE-1:0]  instrrd,
   input  logic                  halt,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [WORD_SIZE-1:0]  instr_out,
   output logic [ADDR_WIDTH-1:0] instr_pc
);

`ifdef MCPU_FETCH_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [ADDR_WIDTH-1:0] pc;
   logic [CNT_W-1:0]      count;
   logic                  pop;
   logic                  fetch;

   assign instr_valid = (count != '0);
   assign pop         = instr_valid && instr_ready;
   // A pop frees a slot this same cycle, so a full buffer still fetches while draining.
   assign fetch       = !reset && !halt && !redirect && ((count != FULL) || pop);
   assign instraddr   = pc;

   always_ff @(posedge clk) begin
      if (reset)         pc <= RESET_PC;
      else if (redirect) pc <= redirect_addr;
      else if (fetch)    pc <= pc + ADDR_WIDTH'(1);
   end

   mcpu_fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect),
      .push      (fetch),
      .push_addr (pc),
      .push_word (instrrd),
      .pop       (pop),
      .count     (count),
      .head_addr (instr_pc),
      .head_word (instr_out)
   );

endmodule
